sobel_window_ctrl: RTL and testbench

Streaming controller that sequences the combinational Sobel datapath (`edge_detection_module`) over a raster-order image. It accepts one pixel per handshake, keeps two line buffers and a 3x3 sliding window, and drives the datapath's eight neighbour inputs. It registers one result per interior pixel and emits it on a valid/ready output stream with frame framing. It sits in the user domain between a pixel source (DMA or register-fed FIFO) and a result sink.

---
 rtl/sobel_window_if.sv | 19 +
 rtl/sobel_window_ctrl.sv | 125 ++++++++++++
 tb/tb_sobel_window_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sobel_window_if.sv
// sobel_window_if: pixel input stream and result output stream of the Sobel window controller
interface sobel_window_if;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  pix_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_mag_o;
  logic        res_edge_o;
  logic        res_last_o;
  modport master (
    input  pix_valid_i, pix_i, res_ready_i,
    output pix_ready_o, res_valid_o, res_mag_o, res_edge_o, res_last_o
  );
  modport slave (
    output pix_valid_i, pix_i, res_ready_i,
    input  pix_ready_o, res_valid_o, res_mag_o, res_edge_o, res_last_o
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: streams a raster image through line buffers and a 3x3 window into the Sobel datapath
module edge_detection_module #(
  parameter int THRESHOLD = 100
) (
  input  logic signed [7:0] p00, p01, p02, p10, p12, p20, p21, p22,
  input  logic              use_threshold,
  output logic [15:0]       mag_o,
  output logic              edge_o
);
  function automatic logic signed [11:0] sx(input logic signed [7:0] v);
    return 12'(v);
  endfunction
  logic signed [11:0] gx, gy;
  logic [11:0] ax, ay;
  assign gx = sx(p02) + (sx(p12) <<< 1) + sx(p22) - sx(p00) - (sx(p10) <<< 1) - sx(p20);
  assign gy = sx(p20) + (sx(p21) <<< 1) + sx(p22) - sx(p00) - (sx(p01) <<< 1) - sx(p02);
  assign ax = gx[11] ? 12'(-gx) : 12'(gx);
  assign ay = gy[11] ? 12'(-gy) : 12'(gy);
  assign mag_o = 16'(ax) + 16'(ay);
  assign edge_o = use_threshold && (int'(mag_o) > THRESHOLD);
endmodule

module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int THRESHOLD  = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic use_threshold_i,
  output logic busy_o,
  output logic done_o,
  sobel_window_if.master s
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic use_th;
  logic [7:0] line_a [IMG_WIDTH];
  logic [7:0] line_b [IMG_WIDTH];
  logic [7:0] win [3][2];
  logic [7:0] a_col, b_col;
  logic accept, emit, res_fire, eol, eof;
  logic [15:0] mag;
  logic edge_f;
  assign a_col    = line_a[col];
  assign b_col    = line_b[col];
  assign accept   = s.pix_valid_i && s.pix_ready_o;
  assign res_fire = s.res_valid_o && s.res_ready_i;
  assign eol      = col == CW'(IMG_WIDTH - 1);
  assign eof      = eol && row == RW'(IMG_HEIGHT - 1);
  assign emit     = accept && row >= RW'(2) && col >= CW'(2);
  edge_detection_module #(.THRESHOLD(THRESHOLD)) u_dp (
    .p00(win[0][0]), .p01(win[0][1]), .p02(b_col),
    .p10(win[1][0]),                  .p12(a_col),
    .p20(win[2][0]), .p21(win[2][1]), .p22(s.pix_i),
    .use_threshold(use_th),
    .mag_o(mag),
    .edge_o(edge_f)
  );
  // next state, input ready and status flags; ready also drops once the frame's final result is pending
  always_comb begin
    state_n = state == IDLE ? (start_i ? FILL : IDLE)
            : state == FILL ? (accept && eol && row == RW'(1) ? RUN : FILL)
            : state == RUN  ? (res_fire && s.res_last_o ? DONE : RUN)
            : IDLE;
    s.pix_ready_o = (state == FILL || state == RUN) && (!s.res_valid_o || s.res_ready_i)
                  && !(s.res_valid_o && s.res_last_o);
    busy_o = state != IDLE;
    done_o = state == DONE;
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // raster counters and latched threshold enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col    <= '0;
      row    <= '0;
      use_th <= 1'b0;
    end else if (state == IDLE && start_i) begin
      col    <= '0;
      row    <= '0;
      use_th <= use_threshold_i;
    end else if (accept) begin
      col <= eol ? '0 : col + 1'b1;
      row <= eol ? (row == RW'(IMG_HEIGHT - 1) ? '0 : row + 1'b1) : row;
    end
  end
  // single result register; a new load wins over clearing on acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s.res_valid_o <= 1'b0;
      s.res_mag_o   <= '0;
      s.res_edge_o  <= 1'b0;
      s.res_last_o  <= 1'b0;
    end else if (emit) begin
      s.res_valid_o <= 1'b1;
      s.res_mag_o   <= mag;
      s.res_edge_o  <= edge_f;
      s.res_last_o  <= eof;
    end else if (res_fire) begin
      s.res_valid_o <= 1'b0;
    end
  end
  // line buffers and the two stored window columns; the right column is the live {B, A, pixel}
  always_ff @(posedge clk_i) begin
    if (accept) begin
      line_b[col] <= a_col;
      line_a[col] <= s.pix_i;
      win[0][0]   <= win[0][1];
      win[0][1]   <= b_col;
      win[1][0]   <= win[1][1];
      win[1][1]   <= a_col;
      win[2][0]   <= win[2][1];
      win[2][1]   <= s.pix_i;
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: drives whole frames and compares every result with a 2D-image Sobel model
module tb_sobel_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int TH = 50;
  logic clk = 1'b0;
  logic rst, start, use_th, busy, done;
  int passed = 0;
  int total  = 0;
  typedef struct {int mag; bit edge_f; bit last;} res_t;
  res_t exp_q[$];
  logic signed [7:0] img [H][W];
  sobel_window_if sif();
  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(TH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .use_threshold_i(use_th),
    .busy_o(busy), .done_o(done), .s(sif)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic check_idle(input string t);
    check({t, "_pix_ready"}, sif.pix_ready_o, 0);
    check({t, "_res_valid"}, sif.res_valid_o, 0);
    check({t, "_res_mag"},   sif.res_mag_o, 0);
    check({t, "_res_edge"},  sif.res_edge_o, 0);
    check({t, "_res_last"},  sif.res_last_o, 0);
    check({t, "_busy"},      busy, 0);
    check({t, "_done"},      done, 0);
  endtask
  function automatic int px(int r, int c);
    return int'(img[r][c]);
  endfunction
  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction
  // modes: 0 constant 10, 1 vertical step 0/20, 2 ramp col+8*row, 3 random
  task automatic build(input int mode, input bit ut);
    int gx, gy, m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = mode == 0 ? 8'sd10 : mode == 1 ? (c >= 4 ? 8'sd20 : 8'sd0)
                  : mode == 2 ? 8'(c + 8 * r) : 8'($urandom_range(255));
    exp_q.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        gx = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1) - px(r-1, c-1) - 2 * px(r, c-1) - px(r+1, c-1);
        gy = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1) - px(r-1, c-1) - 2 * px(r-1, c) - px(r-1, c+1);
        m = iabs(gx) + iabs(gy);
        exp_q.push_back('{m, ut && m > TH, r == H - 2 && c == W - 2});
      end
  endtask
  task automatic run_frame(input int mode, input bit ut, input int gap, input bit bp,
                           input bit poke, input int abort_at);
    int idx = 0, cyc = 0, nres = 0, stall = 0, last_cyc = -10, lat_cyc = -10;
    bit fin = 0;
    logic [15:0] held = '0;
    res_t e;
    build(mode, ut);
    @(negedge clk);
    start = 1'b1;
    use_th = ut;
    sif.pix_valid_i = 1'b0;
    sif.res_ready_i = 1'b1;
    @(negedge clk);
    use_th = !ut;
    while (!fin && cyc < 3000) begin
      start = poke && idx >= 2 * W + 2 && idx < 2 * W + 4;
      sif.pix_valid_i = idx < W * H && $urandom_range(99) >= gap;
      sif.pix_i = idx < W * H ? img[idx / W][idx % W] : 8'd0;
      sif.res_ready_i = !(bp && nres == 3 && stall < 5 && sif.res_valid_o);
      #1;
      if (!sif.res_ready_i) begin
        if (stall == 0) held = sif.res_mag_o;
        check("bp_pix_ready", sif.pix_ready_o, 0);
        check("bp_mag_hold", sif.res_mag_o, held);
        stall++;
      end
      if (cyc == lat_cyc + 1) check("first_latency", sif.res_valid_o, 1);
      if (done) begin
        check("done_after_last", cyc, last_cyc + 1);
        check("busy_in_done", busy, 1);
        check("result_count", nres, (W - 2) * (H - 2));
        fin = 1;
      end
      if (sif.res_valid_o && sif.res_ready_i) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_mag", sif.res_mag_o, e.mag);
          check("res_edge", sif.res_edge_o, e.edge_f);
          check("res_last", sif.res_last_o, e.last);
          if (sif.res_last_o) last_cyc = cyc;
          nres++;
        end
      end
      if (sif.pix_valid_i && sif.pix_ready_o) begin
        if (idx == 2 * W + 2) lat_cyc = cyc;
        idx++;
        if (abort_at > 0 && idx == abort_at) begin
          @(negedge clk);
          rst = 1'b1;
          sif.pix_valid_i = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          #1;
          check_idle("abort");
          sif.pix_valid_i = 1'b1;
          #1;
          check("abort_needs_start", sif.pix_ready_o, 0);
          @(negedge clk);
          sif.pix_valid_i = 1'b0;
          check("abort_still_idle", busy, 0);
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    sif.pix_valid_i = 1'b0;
    if (!fin) check("frame_timeout", 0, 1);
    else begin
      #1;
      check("busy_drop", busy, 0);
      check("done_single_pulse", done, 0);
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    use_th = 1'b0;
    sif.pix_valid_i = 1'b0;
    sif.pix_i = '0;
    sif.res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    run_frame(0, 1, 0, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0, 0);
    run_frame(1, 1, 0, 1, 0, 0);
    run_frame(2, 1, 40, 0, 0, 0);
    run_frame(3, 1, 20, 0, 1, 0);
    run_frame(2, 1, 0, 0, 0, 10);
    run_frame(3, 1, 0, 0, 0, 0);
    run_frame(3, 0, 30, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
